// File: rtl/note_clock_bank.sv
// Bank of NUM_CH independent note clocks: programmable half-period divisors with
// glitch-free shadow/active reload and a global octave shift.
module note_clock_bank #(
    parameter int NUM_CH      = 15,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 14204,
    parameter int OCT_W       = 2
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       enable,
    input  logic [NUM_CH-1:0]          ch_en,
    input  logic [OCT_W-1:0]           oct_shift,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_CH)-1:0]  wr_addr,
    input  logic [DIV_W-1:0]           wr_data,
    output logic [NUM_CH-1:0]          clk_out,
    output logic [NUM_CH-1:0]          tick,
    output logic [NUM_CH-1:0]          pending
);

    logic [DIV_W-1:0] shadow  [NUM_CH];
    logic [DIV_W-1:0] active  [NUM_CH];
    logic [DIV_W-1:0] cnt     [NUM_CH];
    logic [DIV_W-1:0] eff_div [NUM_CH];

    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] boundary;
    logic [NUM_CH-1:0] xfer;
    logic [NUM_CH-1:0] wr_hit;
    logic              addr_ok;

    // The '>=' compare lets a shrinking divisor or shift end the half-period at once
    // instead of letting the counter run all the way around.
    always_comb begin
        addr_ok = (int'(wr_addr) < NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            eff_div[i]  = active[i] >> oct_shift;
            run[i]      = enable & ch_en[i] & (eff_div[i] != '0);
            boundary[i] = run[i] & (cnt[i] >= (eff_div[i] - DIV_W'(1)));
            xfer[i]     = boundary[i] | ~run[i];
            wr_hit[i]   = wr_en & addr_ok & (int'(wr_addr) == i);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= DIV_W'(DEFAULT_DIV);
                active[i] <= DIV_W'(DEFAULT_DIV);
                cnt[i]    <= '0;
            end
            clk_out <= '0;
            tick    <= '0;
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // Active only changes at a half-period boundary or while idle,
                // so a write can never produce a runt pulse.
                if (wr_hit[i]) begin
                    shadow[i] <= wr_data;
                    if (xfer[i]) begin
                        active[i]  <= wr_data;
                        pending[i] <= 1'b0;
                    end else begin
                        pending[i] <= 1'b1;
                    end
                end else if (pending[i] && xfer[i]) begin
                    active[i]  <= shadow[i];
                    pending[i] <= 1'b0;
                end

                if (run[i]) begin
                    if (boundary[i]) begin
                        cnt[i]     <= '0;
                        clk_out[i] <= ~clk_out[i];
                        tick[i]    <= ~clk_out[i];
                    end else begin
                        cnt[i]  <= cnt[i] + DIV_W'(1);
                        tick[i] <= 1'b0;
                    end
                end else begin
                    cnt[i]     <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_note_clock_bank.sv
// Self-checking bench for note_clock_bank: directed long-period checks, a vector
// table for single-channel corner cases, and randomized traffic against a model.
module tb_note_clock_bank;

    localparam int NUM_CH      = 15;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 14204;
    localparam int OCT_W       = 2;

    localparam logic [14:0] Z  = 15'h0000;
    localparam logic [14:0] B4 = 15'h0010;
    localparam logic [14:0] B1 = 15'h0002;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              enable;
    logic [14:0]       ch_en;
    logic [1:0]        oct_shift;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [15:0]       wr_data;
    logic [14:0]       clk_out;
    logic [14:0]       tick;
    logic [14:0]       pending;

    int checks = 0;
    int errors = 0;

    note_clock_bank #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV), .OCT_W(OCT_W)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .enable(enable), .ch_en(ch_en),
        .oct_shift(oct_shift), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clk_out(clk_out), .tick(tick), .pending(pending)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rst_n;
        logic        en;
        logic [14:0] chen;
        logic [1:0]  oct;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [14:0] exp_clk;
        logic [14:0] exp_tick;
        logic [14:0] exp_pend;
    } vec_t;

    vec_t tbl [32];

    // Reference model: per-channel half-period progress kept as plain integers.
    int          m_shadow  [NUM_CH];
    int          m_active  [NUM_CH];
    int          m_elapsed [NUM_CH];
    logic [14:0] m_lvl;
    logic [14:0] m_tick;
    logic [14:0] m_pend;

    function automatic vec_t mk(input logic r, input logic e, input logic [14:0] c,
                                input logic [1:0] o, input logic w, input logic [3:0] a,
                                input logic [15:0] d, input logic [14:0] ec,
                                input logic [14:0] et, input logic [14:0] ep);
        vec_t v;
        v.rst_n = r; v.en = e; v.chen = c; v.oct = o; v.we = w; v.wa = a; v.wd = d;
        v.exp_clk = ec; v.exp_tick = et; v.exp_pend = ep;
        return v;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [14:0] c,
                                 input logic [1:0] o, input logic w, input logic [3:0] a,
                                 input logic [15:0] d);
        RST_N = r; enable = e; ch_en = c; oct_shift = o; wr_en = w; wr_addr = a; wr_data = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelEdge();
        for (int c = 0; c < NUM_CH; c++) begin
            int eff;
            bit running, done, swap, hit;
            if (!RST_N) begin
                m_shadow[c] = DEFAULT_DIV; m_active[c] = DEFAULT_DIV; m_elapsed[c] = 0;
                m_lvl[c] = 1'b0; m_tick[c] = 1'b0; m_pend[c] = 1'b0;
            end else begin
                eff     = m_active[c] >> oct_shift;
                running = enable && ch_en[c] && (eff != 0);
                done    = running && (m_elapsed[c] + 1 >= eff);
                swap    = done || !running;
                hit     = wr_en && (int'(wr_addr) == c);
                if (hit) begin
                    m_shadow[c] = int'(wr_data);
                    if (swap) begin
                        m_active[c] = int'(wr_data);
                        m_pend[c]   = 1'b0;
                    end else begin
                        m_pend[c] = 1'b1;
                    end
                end else if (m_pend[c] && swap) begin
                    m_active[c] = m_shadow[c];
                    m_pend[c]   = 1'b0;
                end
                if (!running) begin
                    m_elapsed[c] = 0; m_lvl[c] = 1'b0; m_tick[c] = 1'b0;
                end else if (done) begin
                    m_elapsed[c] = 0; m_tick[c] = !m_lvl[c]; m_lvl[c] = !m_lvl[c];
                end else begin
                    m_elapsed[c] = m_elapsed[c] + 1; m_tick[c] = 1'b0;
                end
            end
        end
    endtask

    task automatic waitTick(input int ch, output bit found);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            if (tick[ch]) found = 1'b1;
        end
        checkOutput("wait_tick", 32'(found), 32'd1);
    endtask

    task automatic measurePeriod(input int ch, input int expected, input string name);
        bit f, got;
        int per;
        waitTick(ch, f);
        per = 0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            step();
            per++;
            if (tick[ch]) got = 1'b1;
        end
        checkOutput(name, got ? 32'(per) : 32'd0, 32'(expected));
    endtask

    initial begin
        int first_rise, fall, second_rise, tick0_cnt, tick2_cnt, tick2_bad, prev2;
        bit f;
        logic        rr, re, rw;
        logic [14:0] rc;
        logic [1:0]  ro;
        logic [3:0]  ra;
        logic [15:0] rd;

        // Single-channel scenario on ch4 starting from reset.
        tbl[0]  = mk(1'b1, 1'b1, Z,  2'd0, 1'b1, 4'd4,  16'd2, Z,  Z,  Z);
        tbl[1]  = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, Z,  Z,  Z);
        tbl[2]  = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, B4, B4, Z);
        tbl[3]  = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, B4, Z,  Z);
        tbl[4]  = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, Z,  Z,  Z);
        tbl[5]  = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, Z,  Z,  Z);
        tbl[6]  = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, B4, B4, Z);
        tbl[7]  = mk(1'b1, 1'b1, Z,  2'd0, 1'b0, 4'd0,  16'd0, Z,  Z,  Z);
        tbl[8]  = mk(1'b1, 1'b1, Z,  2'd0, 1'b1, 4'd4,  16'd5, Z,  Z,  Z);
        tbl[9]  = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, Z,  Z,  Z);
        tbl[10] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, Z,  Z,  Z);
        tbl[11] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, Z,  Z,  Z);
        tbl[12] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, Z,  Z,  Z);
        tbl[13] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, B4, B4, Z);
        tbl[14] = mk(1'b1, 1'b1, B4, 2'd0, 1'b1, 4'd15, 16'd7, B4, Z,  Z);
        tbl[15] = mk(1'b1, 1'b1, B4, 2'd0, 1'b1, 4'd4,  16'd5, B4, Z,  B4);
        tbl[16] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, B4, Z,  B4);
        tbl[17] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, B4, Z,  B4);
        tbl[18] = mk(1'b1, 1'b1, B4, 2'd0, 1'b1, 4'd4,  16'd1, Z,  Z,  Z);
        tbl[19] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, B4, B4, Z);
        tbl[20] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, Z,  Z,  Z);
        tbl[21] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, B4, B4, Z);
        tbl[22] = mk(1'b1, 1'b1, B4, 2'd0, 1'b1, 4'd4,  16'd0, Z,  Z,  Z);
        tbl[23] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, Z,  Z,  Z);
        tbl[24] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, Z,  Z,  Z);
        tbl[25] = mk(1'b1, 1'b1, B4, 2'd0, 1'b1, 4'd4,  16'd3, Z,  Z,  Z);
        tbl[26] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, Z,  Z,  Z);
        tbl[27] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, Z,  Z,  Z);
        tbl[28] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, B4, B4, Z);
        tbl[29] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, B4, Z,  Z);
        tbl[30] = mk(1'b0, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, Z,  Z,  Z);
        tbl[31] = mk(1'b1, 1'b1, B4, 2'd0, 1'b0, 4'd0,  16'd0, Z,  Z,  Z);

        applyStimulus(1'b0, 1'b0, Z, 2'd0, 1'b0, 4'd0, 16'd0);
        step();
        step();
        checkOutput("reset_clk_out", 32'(clk_out), 32'd0);
        checkOutput("reset_tick", 32'(tick), 32'd0);
        checkOutput("reset_pending", 32'(pending), 32'd0);

        // Default divisor on every channel, with a ch2 reload injected mid half-period.
        $display("[TB] default divisor run");
        applyStimulus(1'b1, 1'b1, 15'h7FFF, 2'd0, 1'b0, 4'd0, 16'd0);
        first_rise = -1; fall = -1; second_rise = -1;
        tick0_cnt = 0; tick2_cnt = 0; tick2_bad = 0; prev2 = 14204;
        for (int n = 1; n <= 42620; n++) begin
            step();
            if (n == 100) applyStimulus(1'b1, 1'b1, 15'h7FFF, 2'd0, 1'b1, 4'd2, 16'd3);
            if (n == 101) begin
                checkOutput("pending2_set", 32'(pending[2]), 32'd1);
                applyStimulus(1'b1, 1'b1, 15'h7FFF, 2'd0, 1'b0, 4'd0, 16'd0);
            end
            if (n == 14203) checkOutput("pending2_hold", 32'(pending[2]), 32'd1);
            if (n == 14204) checkOutput("pending2_clear", 32'(pending[2]), 32'd0);
            if (tick[0]) tick0_cnt++;
            if (clk_out[0] && first_rise < 0) begin
                first_rise = n;
                checkOutput("tick0_at_rise", 32'(tick[0]), 32'd1);
            end
            if (first_rise > 0 && n == first_rise + 1)
                checkOutput("tick0_width", 32'(tick[0]), 32'd0);
            if (first_rise > 0 && !clk_out[0] && fall < 0) fall = n;
            if (fall > 0 && clk_out[0] && second_rise < 0) second_rise = n;
            if (n > 14204 && n <= 14240 && tick[2]) begin
                tick2_cnt++;
                if (n - prev2 != 6) tick2_bad++;
                prev2 = n;
            end
        end
        checkOutput("ch0_first_rise", 32'(first_rise), 32'd14204);
        checkOutput("ch0_fall", 32'(fall), 32'd28408);
        checkOutput("ch0_second_rise", 32'(second_rise), 32'd42612);
        checkOutput("ch0_tick_count", 32'(tick0_cnt), 32'd2);
        checkOutput("ch2_tick_count", 32'(tick2_cnt), 32'd6);
        checkOutput("ch2_tick_spacing", 32'(tick2_bad), 32'd0);

        $display("[TB] vector table");
        applyStimulus(1'b0, 1'b1, Z, 2'd0, 1'b0, 4'd0, 16'd0);
        step();
        for (int r = 0; r < 32; r++) begin
            applyStimulus(tbl[r].rst_n, tbl[r].en, tbl[r].chen, tbl[r].oct,
                          tbl[r].we, tbl[r].wa, tbl[r].wd);
            step();
            checkOutput($sformatf("row%0d_clk", r), 32'(clk_out), 32'(tbl[r].exp_clk));
            checkOutput($sformatf("row%0d_tick", r), 32'(tick), 32'(tbl[r].exp_tick));
            checkOutput($sformatf("row%0d_pend", r), 32'(pending), 32'(tbl[r].exp_pend));
        end

        // ch1 divisor 8 under octave shifts, then a shift that lands below cnt.
        $display("[TB] octave shift sequence");
        applyStimulus(1'b0, 1'b1, Z, 2'd0, 1'b0, 4'd0, 16'd0);
        step();
        applyStimulus(1'b1, 1'b1, Z, 2'd0, 1'b1, 4'd1, 16'd8);
        step();
        applyStimulus(1'b1, 1'b1, B1, 2'd0, 1'b0, 4'd0, 16'd0);
        measurePeriod(1, 16, "ch1_period_oct0");
        oct_shift = 2'd1;
        measurePeriod(1, 8, "ch1_period_oct1");
        oct_shift = 2'd3;
        measurePeriod(1, 2, "ch1_period_oct3");
        oct_shift = 2'd0;
        waitTick(1, f);
        for (int k = 0; k < 6; k++) step();
        oct_shift = 2'd3;
        step();
        checkOutput("shrink_clk_fall", 32'(clk_out[1]), 32'd0);
        checkOutput("shrink_tick_low", 32'(tick[1]), 32'd0);
        step();
        checkOutput("shrink_clk_rise", 32'(clk_out[1]), 32'd1);
        checkOutput("shrink_tick_high", 32'(tick[1]), 32'd1);

        $display("[TB] randomized traffic against model");
        applyStimulus(1'b0, 1'b0, Z, 2'd0, 1'b0, 4'd0, 16'd0);
        modelEdge();
        step();
        rc = 15'h7FFF;
        ro = 2'd0;
        for (int n = 0; n < 4000; n++) begin
            rr = ($urandom_range(0, 699) != 0);
            re = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 7) == 0) rc = rc ^ (15'd1 << $urandom_range(0, 14));
            if ($urandom_range(0, 49) == 0) ro = 2'($urandom_range(0, 3));
            rw = ($urandom_range(0, 3) == 0);
            ra = 4'($urandom_range(0, 15));
            rd = 16'($urandom_range(0, 10));
            applyStimulus(rr, re, rc, ro, rw, ra, rd);
            modelEdge();
            step();
            checkOutput("rand_clk_out", 32'(clk_out), 32'(m_lvl));
            checkOutput("rand_tick", 32'(tick), 32'(m_tick));
            checkOutput("rand_pending", 32'(pending), 32'(m_pend));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
